// File: rtl/nco_meas_pkg.sv
// nco_meas_pkg: shared state type and gate arithmetic for the
// frequency meter.
package nco_meas_pkg;

    localparam int unsigned MIN_GATE_EXP = 2;

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        LATCH
    } meas_state_e;

    // Timer reload value (gate length - 1), exponent clamped at the minimum.
    function automatic int unsigned gate_len(
        input logic [1:0]  gate_sel,
        input int unsigned gate_log2
    );
        int unsigned sel2;
        int unsigned exp_v;
        sel2 = 32'(gate_sel) << 1;
        if (gate_log2 < sel2 + MIN_GATE_EXP) begin
            exp_v = MIN_GATE_EXP;
        end else begin
            exp_v = gate_log2 - sel2;
        end
        return (32'd1 << exp_v) - 32'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer for an async input followed
// by a rising-edge detector.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/nco_freq_meter.sv
// nco_freq_meter: counts synchronized rising edges of sig_in over a
// power-of-two gate window and publishes a sticky valid/ack result.
module nco_freq_meter #(
    parameter int CNT_W       = 16,
    parameter int GATE_LOG2   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    input  logic [1:0]       gate_sel,
    input  logic             ack,
    output logic [CNT_W-1:0] count_out,
    output logic             valid,
    output logic             overflow,
    output logic             overrun,
    output logic             busy
);

    import nco_meas_pkg::*;

    localparam logic [GATE_LOG2-1:0] TIMER_ONE = GATE_LOG2'(1);
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]     CNT_MAX   = '1;

    logic rise;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sig_in),
        .rise(rise)
    );

    meas_state_e          state_q, state_d;
    logic [GATE_LOG2-1:0] timer_q, timer_d;
    logic [GATE_LOG2-1:0] reload;
    logic [CNT_W-1:0]     edges_q, edges_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 sat_q, sat_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;
    logic                 ovr_q, ovr_d;

    assign reload = GATE_LOG2'(gate_len(gate_sel, GATE_LOG2));

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        edges_d = edges_q;
        count_d = count_q;
        sat_d   = sat_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        ovr_d   = ovr_q;

        if (ack) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    timer_d = reload;
                    edges_d = '0;
                    sat_d   = 1'b0;
                    state_d = GATE;
                end
            end
            GATE: begin
                if (!en) begin
                    edges_d = '0;
                    sat_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                    if (rise) begin
                        if (edges_q == CNT_MAX) begin
                            sat_d = 1'b1;
                        end else begin
                            edges_d = edges_q + CNT_ONE;
                        end
                    end
                    if (timer_q == '0) begin
                        state_d = LATCH;
                    end
                end
            end
            LATCH: begin
                // A fresh result beats a coincident ack.
                count_d = edges_q;
                ovf_d   = sat_q;
                valid_d = 1'b1;
                if (valid_q && !ack) begin
                    ovr_d = 1'b1;
                end
                timer_d = reload;
                edges_d = rise ? CNT_ONE : '0;
                sat_d   = 1'b0;
                state_d = en ? GATE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            edges_q <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            edges_q <= edges_d;
            count_q <= count_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            ovr_q   <= ovr_d;
        end
    end

    assign count_out = count_q;
    assign valid     = valid_q;
    assign overflow  = ovf_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q == GATE);

endmodule

// File: tb/tb_nco_freq_meter.sv
// tb_nco_freq_meter: directed and randomized stimulus checked against
// a window-sum reference model of the frequency meter.
module tb_nco_freq_meter;

    localparam int GL = 8;
    localparam int CW = 6;
    localparam int SS = 2;
    localparam int HN = 32768;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          sig_in = 1'b0;
    logic [1:0]    gate_sel = 2'd0;
    logic          ack = 1'b0;
    logic [CW-1:0] count_out;
    logic          valid;
    logic          overflow;
    logic          overrun;
    logic          busy;

    int checks = 0;
    int errors = 0;

    nco_freq_meter #(
        .CNT_W      (CW),
        .GATE_LOG2  (GL),
        .SYNC_STAGES(SS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sig_in   (sig_in),
        .gate_sel (gate_sel),
        .ack      (ack),
        .count_out(count_out),
        .valid    (valid),
        .overflow (overflow),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: sig_in sampled per edge, rises derived from the
    // sample history, and each result is the sum of rises over its window.
    bit sig_h  [HN];
    bit rise_h [HN];
    int k = -1;
    int rst_edge = -1;
    bit m_open = 1'b0;
    int m_lo = 0;
    int m_close = 0;
    bit m_valid = 1'b0;
    bit m_ovf = 1'b0;
    bit m_ovr = 1'b0;
    int m_cnt = 0;

    function automatic int glen(input int sel);
        int e;
        e = GL - 2 * sel;
        if (e < 2) e = 2;
        return 1 << e;
    endfunction

    function automatic bit samp(input int j);
        if (j < 0 || j <= rst_edge) return 1'b0;
        return sig_h[j];
    endfunction

    always @(posedge clk) begin
        int tot;
        bit latched;
        k = k + 1;
        sig_h[k] = sig_in;
        latched = 1'b0;
        if (rst) begin
            rst_edge = k;
            rise_h[k] = 1'b0;
            m_open = 1'b0;
            m_valid = 1'b0;
            m_ovf = 1'b0;
            m_ovr = 1'b0;
            m_cnt = 0;
        end else begin
            rise_h[k] = samp(k - SS) & ~samp(k - SS - 1);
            if (!m_open) begin
                if (en) begin
                    m_open = 1'b1;
                    m_lo = k + 1;
                    m_close = k + glen(int'(gate_sel));
                end
            end else if (k <= m_close) begin
                if (!en) m_open = 1'b0;
            end else begin
                tot = 0;
                for (int j = m_lo; j <= m_close; j++) tot += int'(rise_h[j]);
                if (m_valid && !ack) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_cnt = (tot > CMAX) ? CMAX : tot;
                m_ovf = (tot > CMAX);
                latched = 1'b1;
                if (en) begin
                    m_lo = k;
                    m_close = k + glen(int'(gate_sel));
                end else begin
                    m_open = 1'b0;
                end
            end
            if (ack && !latched) m_valid = 1'b0;
        end
    end

    int mode = 0;
    int per = 8;
    int ph = 0;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("count", int'(count_out), m_cnt);
            check("valid", int'(valid), int'(m_valid));
            check("ovf", int'(overflow), int'(m_ovf));
            check("ovr", int'(overrun), int'(m_ovr));
            check("busy", int'(busy), int'(m_open && k < m_close));
            ack = 1'b0;
            case (mode)
                1: begin
                    ph++;
                    if (ph >= per / 2) begin
                        ph = 0;
                        sig_in = ~sig_in;
                    end
                end
                2: sig_in = 1'($urandom_range(1, 0));
                3: sig_in = (m_open && k == m_close - 3);
                default: ;
            endcase
        end
    endtask

    task automatic wait_latch();
        int n;
        n = 0;
        while (!(m_open && k == m_close) && n < 2000) begin
            step(1);
            n++;
        end
        if (n >= 2000) check("latch_timeout", n, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cnt"}, int'(count_out), 0);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_ovf"}, int'(overflow), 0);
        check({tag, "_ovr"}, int'(overrun), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int saved;
        int n;

        mode = 1;
        per = 8;
        step(3);
        check_zero("reset");
        rst = 1'b0;
        step(2);

        // Period-8 wave, full 256-cycle gate.
        gate_sel = 2'd0;
        en = 1'b1;
        wait_latch();
        step(1);
        check("p8_first", int'(count_out), 32);
        check("p8_valid", int'(valid), 1);
        check("p8_ovf", int'(overflow), 0);
        ack = 1'b1;
        step(1);
        wait_latch();
        step(1);

        // 64-cycle gate.
        gate_sel = 2'd1;
        step(300);

        // Saturation with a period-2 wave, then quiet input.
        en = 1'b0;
        per = 2;
        ph = 0;
        step(2);
        gate_sel = 2'd0;
        en = 1'b1;
        wait_latch();
        step(1);
        check("sat_cnt", int'(count_out), CMAX);
        check("sat_ovf", int'(overflow), 1);
        mode = 0;
        sig_in = 1'b0;
        wait_latch();
        step(1);
        wait_latch();
        step(1);
        check("quiet_cnt", int'(count_out), 0);
        check("quiet_ovf", int'(overflow), 0);
        check("quiet_ovr", int'(overrun), 1);

        // Reset mid-window with a pending result.
        step(100);
        rst = 1'b1;
        step(1);
        check_zero("midrst");
        rst = 1'b0;

        // Ack coinciding with LATCH, then ack one cycle later.
        mode = 1;
        per = 8;
        gate_sel = 2'd1;
        wait_latch();
        step(1);
        check("w1_ovr", int'(overrun), 0);
        wait_latch();
        ack = 1'b1;
        step(1);
        check("ackl_valid", int'(valid), 1);
        check("ackl_ovr", int'(overrun), 0);
        ack = 1'b1;
        step(1);
        check("ack_clr", int'(valid), 0);
        wait_latch();
        step(1);
        check("w3_ovr", int'(overrun), 0);
        wait_latch();
        step(1);
        check("w4_ovr", int'(overrun), 1);

        // Abort mid-window, then restart with a re-sampled gate_sel.
        gate_sel = 2'd0;
        wait_latch();
        step(1);
        step(100);
        saved = m_cnt;
        en = 1'b0;
        step(1);
        check("abort_busy", int'(busy), 0);
        check("abort_cnt", int'(count_out), saved);
        gate_sel = 2'd1;
        en = 1'b1;
        n = 0;
        do begin
            step(1);
            n++;
        end while (busy && n < 400);
        check("regate_len", n, 65);

        // One pulse per window, landing on the final gate cycle.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        en = 1'b0;
        mode = 3;
        step(2);
        gate_sel = 2'd0;
        en = 1'b1;
        wait_latch();
        step(1);
        check("pulse_cnt1", int'(count_out), 1);
        wait_latch();
        step(1);
        check("pulse_cnt2", int'(count_out), 1);

        // Randomized traffic.
        mode = 2;
        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(199, 0) != 0);
            ack = ($urandom_range(15, 0) == 0);
            gate_sel = 2'($urandom_range(3, 0));
            rst = ($urandom_range(999, 0) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
